// File: rtl/serial_addsub_seq_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
// The master drives the request side; the slave (the sequencer) drives status and results.
interface serial_addsub_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op_sub, a, b,
        input  ready, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, op_sub, a, b,
        output ready, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused over WIDTH cycles,
// LSB first, producing a WIDTH-bit sum/difference with carry, overflow and zero flags.
module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_addsub_seq_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             sum_bit;
    logic             carry_out;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
        carry_out = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
        shifted   = {sum_bit, result_q[WIDTH-1:1]};

        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d = shifted;
                opa_d    = opa_q >> 1;
                opb_d    = opb_q >> 1;
                carry_d  = carry_out;
                cnt_d    = cnt_q + CNT_W'(1);
                // On the MSB, carry_q is still the carry into the MSB.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = carry_out;
                    ovf_d   = carry_q ^ carry_out;
                    zero_d  = (shifted == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed and randomised bench for serial_addsub_seq at WIDTH=8 and WIDTH=32.
// Every scenario task drives its own stimulus and compares against hand values or a signed-arithmetic model.
module tb_serial_addsub_seq;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_addsub_seq_if #(.WIDTH(8))  bus8 ();
    serial_addsub_seq_if #(.WIDTH(32)) bus32 ();

    serial_addsub_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_addsub_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference built on signed-overflow semantics, independent of the carry chain.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, output logic [63:0] r,
                                  output logic c, output logic v, output logic z);
        logic [64:0] mask;
        logic [64:0] t;
        logic [63:0] bb;
        mask = (65'd1 << w) - 65'd1;
        bb   = sub ? (~b & mask[63:0]) : b;
        t    = {1'b0, a} + {1'b0, bb} + {64'd0, sub};
        r    = t[63:0] & mask[63:0];
        c    = t[w];
        v    = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
        z    = (r == 64'd0);
    endfunction

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                           output logic [7:0] r, output logic c, output logic v, output logic z,
                           output int lat, output logic done_fell);
        int guard;
        guard = 0;
        while (!bus8.ready && guard < 50) begin
            tick();
            guard++;
        end
        bus8.a      = a;
        bus8.b      = b;
        bus8.op_sub = sub;
        bus8.start  = 1'b1;
        tick();
        bus8.start  = 1'b0;
        bus8.a      = ~a;
        bus8.b      = 8'h5A;
        bus8.op_sub = ~sub;
        lat = 0;
        while (!bus8.done && lat < 100) begin
            tick();
            lat++;
        end
        r = bus8.result;
        c = bus8.cout;
        v = bus8.overflow;
        z = bus8.zero;
        tick();
        done_fell = !bus8.done && bus8.ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b0;  bus8.op_sub = 1'b0;  bus8.a = '0;  bus8.b = '0;
        bus32.start = 1'b0; bus32.op_sub = 1'b0; bus32.a = '0; bus32.b = '0;
        tick();
        tick();
        total++;
        if (bus8.ready !== 1'b1 || bus8.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_handshake: ready=%b done=%b, want ready=1 done=0", bus8.ready, bus8.done);
        end
        total++;
        if ({bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== 11'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: result=%h c=%b v=%b z=%b, want all 0",
                     bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic [7:0] va [2] = '{8'h7F, 8'hFF};
        logic [7:0] vb [2] = '{8'h01, 8'h01};
        logic [7:0] er [2] = '{8'h80, 8'h00};
        logic       ec [2] = '{1'b0, 1'b1};
        logic       ev [2] = '{1'b1, 1'b0};
        logic       ez [2] = '{1'b0, 1'b1};
        logic [7:0] r;
        logic       c, v, z, fell;
        int         lat;
        for (int i = 0; i < 2; i++) begin
            run_op8(va[i], vb[i], 1'b0, r, c, v, z, lat, fell);
            total++;
            if ({r, c, v, z} !== {er[i], ec[i], ev[i], ez[i]}) begin
                bad++;
                $display("[TB] FAIL add_%0d: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                         i, r, c, v, z, er[i], ec[i], ev[i], ez[i]);
            end
            total++;
            if (lat !== 8) begin
                bad++;
                $display("[TB] FAIL add_latency_%0d: done after %0d edges, want 8", i, lat);
            end
            total++;
            if (fell !== 1'b1) begin
                bad++;
                $display("[TB] FAIL add_done_width_%0d: done/ready after next edge wrong, got %b want 1", i, fell);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0] va [5] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h7F};
        logic [7:0] vb [5] = '{8'h05, 8'h05, 8'h01, 8'h01, 8'hFF};
        logic [7:0] er [5] = '{8'h00, 8'hFE, 8'h7F, 8'hFF, 8'h80};
        logic       ec [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ev [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       ez [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] r;
        logic       c, v, z, fell;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            run_op8(va[i], vb[i], 1'b1, r, c, v, z, lat, fell);
            total++;
            if ({r, c, v, z} !== {er[i], ec[i], ev[i], ez[i]} || lat !== 8) begin
                bad++;
                $display("[TB] FAIL sub_%0d: got r=%h c=%b v=%b z=%b lat=%0d want r=%h c=%b v=%b z=%b lat=8",
                         i, r, c, v, z, lat, er[i], ec[i], ev[i], ez[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int i;
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.op_sub = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        i = 1;
        while (!bus8.done && i < 20) begin
            if (i == 2 || i == 8) begin
                bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.op_sub = 1'b1;
                total++;
                if (bus8.ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL ignore_ready_cycle%0d: ready=%b want 0", i, bus8.ready);
                end
            end else begin
                bus8.start = 1'b0;
            end
            tick();
            i++;
        end
        bus8.start = 1'b0;
        total++;
        if (bus8.result !== 8'h30 || bus8.done !== 1'b1 || i !== 9) begin
            bad++;
            $display("[TB] FAIL ignore_result: r=%h done=%b cycle=%0d want r=30 done=1 cycle=9", bus8.result, bus8.done, i);
        end
        tick();
        total++;
        if (bus8.ready !== 1'b1 || bus8.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ignore_ready_after: ready=%b done=%b want 1/0", bus8.ready, bus8.done);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (bus8.ready !== 1'b1 || bus8.done !== 1'b0 || bus8.result !== 8'h30) begin
                bad++;
                $display("[TB] FAIL ignore_not_queued_%0d: ready=%b done=%b r=%h want 1/0/30", k, bus8.ready, bus8.done, bus8.result);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] r;
        logic       c, v, z, fell;
        int         lat;
        int         done_seen;
        run_op8(8'h80, 8'h01, 1'b1, r, c, v, z, lat, fell);
        total++;
        if ({r, c, v} !== {8'h7F, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL abort_setup: r=%h c=%b v=%b want 7f/1/1", r, c, v);
        end
        bus8.a = 8'h55; bus8.b = 8'h22; bus8.op_sub = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus8.done) done_seen++;
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus8.ready !== 1'b1 || bus8.done !== 1'b0 ||
            {bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== 11'd0) begin
            bad++;
            $display("[TB] FAIL abort_outputs: ready=%b done=%b r=%h c=%b v=%b z=%b want 1/0/00/0/0/0",
                     bus8.ready, bus8.done, bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus8.done) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("[TB] FAIL abort_no_done: saw %0d done cycles, want 0", done_seen);
        end
        run_op8(8'h12, 8'h34, 1'b0, r, c, v, z, lat, fell);
        total++;
        if ({r, c, v, z} !== {8'h46, 1'b0, 1'b0, 1'b0} || lat !== 8 || fell !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_followup: r=%h c=%b v=%b z=%b lat=%0d fell=%b want 46/0/0/0/8/1",
                     r, c, v, z, lat, fell);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] er;
        logic [7:0]  pa, pb;
        logic        ps, ec, ev, ez;
        int          done_cnt, cycles, last_acc, pending;
        done_cnt = 0; cycles = 0; last_acc = -1; pending = 0;
        er = '0; ec = 1'b0; ev = 1'b0; ez = 1'b0;
        bus8.start = 1'b1;
        while (done_cnt < 1000 && cycles < 20000) begin
            if (bus8.done) begin
                total++;
                if (pending == 0 || {bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== {er[7:0], ec, ev, ez}) begin
                    bad++;
                    $display("[TB] FAIL b2b_op%0d: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b pending=%0d",
                             done_cnt, bus8.result, bus8.cout, bus8.overflow, bus8.zero, er[7:0], ec, ev, ez, pending);
                end
                done_cnt++;
                pending = 0;
            end
            if (bus8.ready) begin
                if (last_acc >= 0) begin
                    total++;
                    if (cycles - last_acc !== 10) begin
                        bad++;
                        $display("[TB] FAIL b2b_interval: got %0d clocks want 10", cycles - last_acc);
                    end
                end
                last_acc = cycles;
                pa = 8'($urandom); pb = 8'($urandom); ps = 1'($urandom);
                bus8.a = pa; bus8.b = pb; bus8.op_sub = ps;
                model(8, {56'd0, pa}, {56'd0, pb}, ps, er, ec, ev, ez);
                pending = 1;
            end
            tick();
            cycles++;
        end
        bus8.start = 1'b0;
        total++;
        if (done_cnt !== 1000) begin
            bad++;
            $display("[TB] FAIL b2b_count: completed %0d ops want 1000", done_cnt);
        end
        tick();
        tick();
    endtask

    task automatic test_random32();
        logic [63:0] er;
        logic [31:0] pa, pb;
        logic        ps, ec, ev, ez;
        int          done_cnt, cycles, last_acc, pending;
        done_cnt = 0; cycles = 0; last_acc = -1; pending = 0;
        er = '0; ec = 1'b0; ev = 1'b0; ez = 1'b0;
        bus32.start = 1'b1;
        while (done_cnt < 200 && cycles < 10000) begin
            if (bus32.done) begin
                total++;
                if (pending == 0 || {bus32.result, bus32.cout, bus32.overflow, bus32.zero} !== {er[31:0], ec, ev, ez}) begin
                    bad++;
                    $display("[TB] FAIL w32_op%0d: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                             done_cnt, bus32.result, bus32.cout, bus32.overflow, bus32.zero, er[31:0], ec, ev, ez);
                end
                done_cnt++;
                pending = 0;
            end
            if (bus32.ready) begin
                if (last_acc >= 0) begin
                    total++;
                    if (cycles - last_acc !== 34) begin
                        bad++;
                        $display("[TB] FAIL w32_interval: got %0d clocks want 34", cycles - last_acc);
                    end
                end
                last_acc = cycles;
                pa = $urandom; pb = $urandom; ps = 1'($urandom);
                if (done_cnt == 3) begin pa = 32'h7FFF_FFFF; pb = 32'h0000_0001; ps = 1'b0; end
                if (done_cnt == 4) begin pa = 32'h1234_5678; pb = 32'h1234_5678; ps = 1'b1; end
                bus32.a = pa; bus32.b = pb; bus32.op_sub = ps;
                model(32, {32'd0, pa}, {32'd0, pb}, ps, er, ec, ev, ez);
                pending = 1;
            end
            tick();
            cycles++;
        end
        bus32.start = 1'b0;
        total++;
        if (done_cnt !== 200) begin
            bad++;
            $display("[TB] FAIL w32_count: completed %0d ops want 200", done_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
